// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: default widths, PC increment and the
// fetch FSM state encoding used by fetch_queue.
package cpu_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int INSTR_W_DEF = 32;
   localparam int PC_STEP     = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with push, pop and flush. Flush drops all
// entries by snapping the read pointer onto the write pointer.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [W-1:0]                 wdata,
   output logic [W-1:0]                 rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one outstanding
// imem read at a time and presents the oldest {instr, pc} pair to IF_ID.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  target,
   input  logic               keep,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int ENT_W = INSTR_W + ADDR_W;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;

   logic              push, pop, space, fill_last;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ENT_W-1:0]  head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty, fifo_full;

   assign valid       = !fifo_empty;
   assign pop         = valid && !keep && !jump;
   assign push        = imem_ack && imem_req && (state_q == S_WAIT) && !jump;
   assign space       = !fifo_full || pop;
   assign redirect_pc = {target[ADDR_W-1:2], 2'b00};
   // This push takes the last free slot, so the next request must wait
   assign fill_last   = push && !pop && (fifo_count == CNT_W'(DEPTH-1));

   assign imem_req  = (state_q != S_IDLE);
   assign imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      if (jump) begin
         fetch_pc_d = redirect_pc;
         case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
               // An un-acked request is still in flight; hold its address until it returns
               if (!imem_ack) begin
                  state_d     = S_DROP;
                  drop_addr_d = fetch_pc_q;
               end
            end
            S_DROP:  state_d = S_DROP;
            default: state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (space) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (push) begin
                  fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                  if (fill_last) state_d = S_IDLE;
               end
            end
            S_DROP: begin
               if (imem_ack) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (jump),
      .wdata ({imem_rdata, fetch_pc_q}),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign instr = head[ENT_W-1:ADDR_W];
   assign pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: inputs change and outputs are sampled on
// the falling edge; the memory model returns addr ^ 32'hA5A5_0000.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        jump;
   logic [31:0] target;
   logic        keep;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid;
   logic [31:0] instr;
   logic [31:0] pc;

   int pass_cnt;
   int total_cnt;

   fetch_queue dut (
      .clk        (clk),
      .rst        (rst),
      .jump       (jump),
      .target     (target),
      .keep       (keep),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .valid      (valid),
      .instr      (instr),
      .pc         (pc)
   );

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Holds reset for two edges, then releases it on a falling edge (cycle 0).
   task automatic apply_reset(input logic k, input logic a);
      @(negedge clk);
      rst      = 1'b0;
      jump     = 1'b0;
      target   = '0;
      keep     = k;
      imem_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst      = 1'b1;
      imem_ack = a;
   endtask

   task automatic test_reset;
      rst = 1'b0; jump = 1'b0; target = '0; keep = 1'b0; imem_ack = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
      else pass_cnt++;
      total_cnt++;
      if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid);
      else pass_cnt++;
      total_cnt++;
      if ({instr, pc} !== 64'h0) $display("FAIL reset_head: got instr=%h pc=%h want 0/0", instr, pc);
      else pass_cnt++;
   endtask

   task automatic test_stream;
      logic [31:0] exp_addr, exp_pc;
      apply_reset(1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         exp_addr = 32'(4 * k);
         total_cnt++;
         if ({imem_req, imem_addr} !== {1'b1, exp_addr})
            $display("FAIL stream_addr k=%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, exp_addr);
         else pass_cnt++;
         total_cnt++;
         if (valid !== (k != 0)) $display("FAIL stream_valid k=%0d: got %b want %b", k, valid, (k != 0));
         else pass_cnt++;
         if (k != 0) begin
            exp_pc = 32'(4 * (k - 1));
            total_cnt++;
            if ({pc, instr} !== {exp_pc, exp_pc ^ 32'hA5A5_0000})
               $display("FAIL stream_head k=%0d: got pc=%h instr=%h want pc=%h instr=%h", k, pc, instr, exp_pc, exp_pc ^ 32'hA5A5_0000);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_keep_fill;
      logic        exp_req;
      logic [31:0] exp_addr, exp_pc;
      apply_reset(1'b1, 1'b1);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         exp_addr = '0;
         if (c <= 4) begin
            exp_req = 1'b1; exp_addr = 32'(4 * (c - 1)); exp_pc = '0;
         end else if (c <= 7) begin
            exp_req = 1'b0; exp_pc = '0;
         end else begin
            exp_req = 1'b1; exp_addr = 32'(16 + 4 * (c - 8)); exp_pc = 32'(4 * (c - 7));
         end
         total_cnt++;
         if (imem_req !== exp_req) $display("FAIL fill_req c=%0d: got %b want %b", c, imem_req, exp_req);
         else pass_cnt++;
         if (exp_req) begin
            total_cnt++;
            if (imem_addr !== exp_addr) $display("FAIL fill_addr c=%0d: got %h want %h", c, imem_addr, exp_addr);
            else pass_cnt++;
         end
         total_cnt++;
         if (valid !== (c >= 2)) $display("FAIL fill_valid c=%0d: got %b want %b", c, valid, (c >= 2));
         else pass_cnt++;
         if (c >= 2) begin
            total_cnt++;
            if (pc !== exp_pc) $display("FAIL fill_pc c=%0d: got %h want %h", c, pc, exp_pc);
            else pass_cnt++;
         end
         if (c == 7) keep = 1'b0;
      end
   endtask

   task automatic test_full_no_loss;
      logic [11:0] keep_pat;
      logic [31:0] exp_head;
      keep_pat = 12'b0001_0001_0010;
      exp_head = '0;
      apply_reset(1'b1, 1'b1);
      repeat (6) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         if (i != 0) @(negedge clk);
         total_cnt++;
         if ({valid, pc, instr} !== {1'b1, exp_head, exp_head ^ 32'hA5A5_0000})
            $display("FAIL full_head i=%0d: got valid=%b pc=%h instr=%h want valid=1 pc=%h", i, valid, pc, instr, exp_head);
         else pass_cnt++;
         keep = keep_pat[i];
         if (!keep) exp_head = exp_head + 32'd4;
      end
   endtask

   task automatic test_jump_with_ack;
      apply_reset(1'b1, 1'b1);
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({valid, pc, imem_addr} !== {1'b1, 32'h0, 32'h4})
         $display("FAIL jack_pre: got valid=%b pc=%h addr=%h want 1/0/4", valid, pc, imem_addr);
      else pass_cnt++;
      jump = 1'b1; target = 32'h103;
      @(negedge clk);
      jump = 1'b0;
      total_cnt++;
      if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100})
         $display("FAIL jack_redirect: got valid=%b req=%b addr=%h want 0/1/100", valid, imem_req, imem_addr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({valid, pc, instr, imem_addr} !== {1'b1, 32'h100, 32'hA5A5_0100, 32'h104})
         $display("FAIL jack_first: got valid=%b pc=%h instr=%h addr=%h want 1/100/a5a50100/104", valid, pc, instr, imem_addr);
      else pass_cnt++;
   endtask

   task automatic test_jump_delayed_ack;
      apply_reset(1'b0, 1'b0);
      @(negedge clk);
      total_cnt++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL drop_start: got req=%b addr=%h want 1/0", imem_req, imem_addr);
      else pass_cnt++;
      jump = 1'b1; target = 32'h200;
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         jump = 1'b0;
         total_cnt++;
         if ({imem_req, imem_addr, valid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL drop_hold c=%0d: got req=%b addr=%h valid=%b want 1/0/0", c, imem_req, imem_addr, valid);
         else pass_cnt++;
         if (c == 3) begin jump = 1'b1; target = 32'h302; end
         if (c == 4) imem_ack = 1'b1;
      end
      for (int c = 5; c <= 6; c++) begin
         @(negedge clk);
         imem_ack = 1'b0;
         total_cnt++;
         if ({imem_req, imem_addr, valid} !== {1'b1, 32'h300, 1'b0})
            $display("FAIL drop_retarget c=%0d: got req=%b addr=%h valid=%b want 1/300/0", c, imem_req, imem_addr, valid);
         else pass_cnt++;
      end
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      total_cnt++;
      if ({valid, pc, instr, imem_addr} !== {1'b1, 32'h300, 32'hA5A5_0300, 32'h304})
         $display("FAIL drop_first: got valid=%b pc=%h instr=%h addr=%h want 1/300/a5a50300/304", valid, pc, instr, imem_addr);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_wait;
      apply_reset(1'b1, 1'b1);
      repeat (3) @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({imem_req, imem_addr, valid, pc} !== {1'b1, 32'h8, 1'b1, 32'h0})
         $display("FAIL rmid_pre: got req=%b addr=%h valid=%b pc=%h want 1/8/1/0", imem_req, imem_addr, valid, pc);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({imem_req, valid, pc, instr} !== {1'b0, 1'b0, 32'h0, 32'h0})
         $display("FAIL rmid_reset: got req=%b valid=%b pc=%h instr=%h want 0/0/0/0", imem_req, valid, pc, instr);
      else pass_cnt++;
      rst = 1'b1; imem_ack = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({imem_req, imem_addr, valid} !== {1'b1, 32'h0, 1'b0})
         $display("FAIL rmid_restart: got req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({valid, pc, instr} !== {1'b1, 32'h0, 32'hA5A5_0000})
         $display("FAIL rmid_first: got valid=%b pc=%h instr=%h want 1/0/a5a50000", valid, pc, instr);
      else pass_cnt++;
   endtask

   task automatic test_pc_wrap;
      apply_reset(1'b1, 1'b1);
      @(negedge clk);
      jump = 1'b1; target = 32'hFFFF_FFFF;
      @(negedge clk);
      jump = 1'b0;
      total_cnt++;
      if ({imem_req, imem_addr, valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0})
         $display("FAIL wrap_target: got req=%b addr=%h valid=%b want 1/fffffffc/0", imem_req, imem_addr, valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({valid, pc, instr, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0})
         $display("FAIL wrap_next: got valid=%b pc=%h instr=%h addr=%h want 1/fffffffc/5a5afffc/0", valid, pc, instr, imem_addr);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_stream();
      test_keep_fill();
      test_full_no_loss();
      test_jump_with_ack();
      test_jump_delayed_ack();
      test_reset_mid_wait();
      test_pc_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
